// File: rtl/mem_access_controller.sv
// Requester-side sequencer for a 4K x 16 unified memory: turns single or burst
// load/store requests into memory cycles behind valid/ready handshakes.
module mem_access_controller #(
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 16,
  parameter int                LEN_W     = 5,
  parameter logic [ADDR_W-1:0] DATA_BASE = 'h800
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_Write,
  output logic              mem_Read,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DRAIN,
    S_WR,
    S_DONE,
    S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;

  logic [ADDR_W:0]     last_addr;
  logic                req_illegal;
  logic                last_word;
  logic                rd_capture;

  // The one-bit-wider sum exposes bursts that would wrap past the top of memory.
  assign last_addr   = {1'b0, req_addr} + (ADDR_W+1)'(req_len) - (ADDR_W+1)'(1);
  assign req_illegal = (req_len == '0)
                     || (last_addr > {1'b0, {ADDR_W{1'b1}}})
                     || (req_write && (req_addr < DATA_BASE));
  assign last_word   = (remain_q == LEN_W'(1));
  assign rd_capture  = !rd_valid_q || rd_ready;

  // NOTE: every output and *_d gets a default before the case so that no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    fault_addr_d = fault_addr_q;
    mem_Read     = 1'b0;
    mem_Write    = 1'b0;
    mem_address  = cur_addr_q;
    mem_data_in  = '0;
    wr_ready     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            state_d      = S_FAULT;
            fault_addr_d = req_addr;
          end else begin
            cur_addr_d = req_addr;
            remain_d   = req_len;
            state_d    = req_write ? S_WR : S_RD;
          end
        end
      end

      S_RD: begin
        mem_Read = 1'b1;
        // A word is captured whenever the output register is empty or being emptied.
        if (rd_capture) begin
          rd_data_d  = mem_data_out;
          rd_valid_d = 1'b1;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          if (last_word) state_d = S_RD_DRAIN;
        end
      end

      S_RD_DRAIN: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = S_DONE;
        end
      end

      S_WR: begin
        wr_ready    = 1'b1;
        mem_Write   = wr_valid;
        mem_data_in = wr_data;
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          if (last_word) state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remain_q     <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign fault_addr = fault_addr_q;

endmodule
